// File: rtl/ppu_sched_pkg.sv
// Shared types and default geometry for the PPU tile scheduler.
package ppu_sched_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GRANT  = 3'd1,
    STREAM = 3'd2,
    WAIT   = 3'd3,
    WRITE  = 3'd4
  } state_e;

  localparam int PPU_ROWS    = 16;
  localparam int PPU_PSUM_W  = 384;
  localparam int PPU_OUT_W   = 128;
  localparam int PPU_TIMEOUT = 255;

  // Index width that stays legal when a count of one would give $clog2 == 0.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ppu_tile_sched_rr_arbiter.sv
// Pointer-based round-robin arbiter: first requester at/after the pointer wins.
module rr_arbiter
  import ppu_sched_pkg::*;
#(
  parameter int NREQ   = 2,
  localparam int IDX_W = idx_w(NREQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req,
  input  logic             adv,
  input  logic [IDX_W-1:0] adv_idx,
  output logic             any,
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  logic [IDX_W-1:0] ptr_q;
  int               j;

  always_comb begin
    any     = 1'b0;
    gnt_idx = '0;
    gnt     = '0;
    j       = 0;
    for (int i = 0; i < NREQ; i++) begin
      j = int'(ptr_q) + i;
      if (j >= NREQ) j = j - NREQ;
      if (!any && req[j]) begin
        any     = 1'b1;
        gnt_idx = IDX_W'(j);
      end
    end
    gnt[gnt_idx] = any;
  end

  // The bank just served drops to lowest priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (adv) begin
      ptr_q <= (int'(adv_idx) == NREQ - 1) ? '0 : adv_idx + 1'b1;
    end
  end

endmodule

// File: rtl/ppu_tile_sched.sv
// Time-shares one post-processing unit between NREQ accumulator banks:
// arbitrate, stream ROWS partial-sum rows, wait for the done edge, write the tagged result.
module ppu_tile_sched
  import ppu_sched_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int ADDR_W  = 6,
  parameter int ROWS    = PPU_ROWS,
  parameter int PSUM_W  = PPU_PSUM_W,
  parameter int OUT_W   = PPU_OUT_W,
  parameter int TIMEOUT = PPU_TIMEOUT,
  localparam int IDX_W  = idx_w(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [8*NREQ-1:0]      req_scale,
  input  logic [8*NREQ-1:0]      req_bias,
  input  logic [ADDR_W*NREQ-1:0] req_base,
  output logic                   acc_rd_en,
  output logic [IDX_W-1:0]       acc_rd_bank,
  output logic [ADDR_W-1:0]      acc_rd_addr,
  input  logic [PSUM_W-1:0]      acc_rd_data,
  output logic                   ppu_valid,
  output logic [PSUM_W-1:0]      ppu_psum,
  output logic [7:0]             ppu_scale,
  output logic [7:0]             ppu_bias,
  input  logic                   ppu_done,
  input  logic [OUT_W-1:0]       ppu_out,
  output logic                   out_wr_en,
  output logic [IDX_W-1:0]       out_wr_bank,
  output logic [OUT_W-1:0]       out_wr_data,
  output logic                   busy,
  output logic                   timeout_err,
  input  logic                   err_clr
);

  localparam int ROW_W = idx_w(ROWS);
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   g_q;
  logic [NREQ-1:0]    gnt_oh_q;
  logic [ADDR_W-1:0]  base_q;
  logic [ROW_W-1:0]   row_q;
  logic [TMO_W-1:0]   wcnt_q;
  logic               done_p1;
  logic               rd_vld_p1;
  logic               done_edge;
  logic               ld_desc;
  logic               cap;
  logic               tmo;

  logic               arb_any;
  logic [NREQ-1:0]    arb_gnt;
  logic [IDX_W-1:0]   arb_idx;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_valid),
    .adv     (ld_desc),
    .adv_idx (g_q),
    .any     (arb_any),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  // A level already high when WAIT is entered must not count, so the
  // done history is tracked in every state.
  assign done_edge = ppu_done & ~done_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    acc_rd_en = 1'b0;
    ppu_valid = 1'b0;
    out_wr_en = 1'b0;
    ld_desc   = 1'b0;
    cap       = 1'b0;
    tmo       = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_any) state_d = GRANT;
      end
      GRANT: begin
        req_ready = gnt_oh_q;
        ld_desc   = 1'b1;
        state_d   = STREAM;
      end
      STREAM: begin
        acc_rd_en = 1'b1;
        ppu_valid = (row_q == '0);
        if (row_q == ROW_W'(ROWS - 1)) state_d = WAIT;
      end
      WAIT: begin
        if (done_edge) begin
          cap     = 1'b1;
          state_d = WRITE;
        end else if (wcnt_q == TMO_W'(TIMEOUT)) begin
          tmo     = 1'b1;
          state_d = IDLE;
        end
      end
      WRITE: begin
        out_wr_en = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Grant capture: winner is frozen in IDLE so GRANT acknowledges exactly it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g_q      <= '0;
      gnt_oh_q <= '0;
    end else if (state_q == IDLE && arb_any) begin
      g_q      <= arb_idx;
      gnt_oh_q <= arb_gnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q       <= '0;
      wcnt_q      <= '0;
      done_p1     <= 1'b0;
      rd_vld_p1   <= 1'b0;
      ppu_scale   <= '0;
      ppu_bias    <= '0;
      out_wr_data <= '0;
      timeout_err <= 1'b0;
    end else begin
      row_q     <= (state_q == STREAM) ? row_q + 1'b1 : '0;
      wcnt_q    <= (state_q == WAIT) ? wcnt_q + 1'b1 : '0;
      done_p1   <= ppu_done;
      rd_vld_p1 <= acc_rd_en;
      if (ld_desc) begin
        ppu_scale <= req_scale[8*int'(g_q) +: 8];
        ppu_bias  <= req_bias[8*int'(g_q) +: 8];
      end
      if (cap) out_wr_data <= ppu_out;
      if (err_clr)  timeout_err <= 1'b0;
      else if (tmo) timeout_err <= 1'b1;
    end
  end

  // Row base is pure datapath; every use of it is gated by acc_rd_en.
  always_ff @(posedge clk) begin
    if (ld_desc) base_q <= req_base[ADDR_W*int'(g_q) +: ADDR_W];
  end

  // Read stage boundary: SRAM data returns one cycle after the strobe.
  assign acc_rd_bank = g_q;
  assign acc_rd_addr = acc_rd_en ? base_q + ADDR_W'(row_q) : '0;
  assign ppu_psum    = rd_vld_p1 ? acc_rd_data : '0;

  assign out_wr_bank = g_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_ppu_tile_sched.sv
// Directed bench for ppu_tile_sched: table of tiles plus timeout, held-done and mid-tile reset sequences.
module tb_ppu_tile_sched;

  localparam int NREQ   = 2;
  localparam int ADDR_W = 6;
  localparam int PSUM_W = 384;
  localparam int OUT_W  = 128;

  logic                   clk;
  logic                   rst_n;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [8*NREQ-1:0]      req_scale;
  logic [8*NREQ-1:0]      req_bias;
  logic [ADDR_W*NREQ-1:0] req_base;
  logic                   acc_rd_en;
  logic [0:0]             acc_rd_bank;
  logic [ADDR_W-1:0]      acc_rd_addr;
  logic [PSUM_W-1:0]      acc_rd_data;
  logic                   ppu_valid;
  logic [PSUM_W-1:0]      ppu_psum;
  logic [7:0]             ppu_scale;
  logic [7:0]             ppu_bias;
  logic                   ppu_done;
  logic [OUT_W-1:0]       ppu_out;
  logic                   out_wr_en;
  logic [0:0]             out_wr_bank;
  logic [OUT_W-1:0]       out_wr_data;
  logic                   busy;
  logic                   timeout_err;
  logic                   err_clr;

  ppu_tile_sched #(.NREQ(NREQ), .ADDR_W(ADDR_W), .ROWS(16), .PSUM_W(PSUM_W),
                   .OUT_W(OUT_W), .TIMEOUT(255)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_scale(req_scale), .req_bias(req_bias), .req_base(req_base),
    .acc_rd_en(acc_rd_en), .acc_rd_bank(acc_rd_bank), .acc_rd_addr(acc_rd_addr),
    .acc_rd_data(acc_rd_data),
    .ppu_valid(ppu_valid), .ppu_psum(ppu_psum), .ppu_scale(ppu_scale), .ppu_bias(ppu_bias),
    .ppu_done(ppu_done), .ppu_out(ppu_out),
    .out_wr_en(out_wr_en), .out_wr_bank(out_wr_bank), .out_wr_data(out_wr_data),
    .busy(busy), .timeout_err(timeout_err), .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [PSUM_W-1:0] psum_of(input logic b, input logic [5:0] a);
    return {48{{1'b0, b, a}}};
  endfunction

  // Accumulator SRAM model: one-cycle read latency, garbage when not read.
  always @(posedge clk) begin
    if (acc_rd_en) acc_rd_data <= psum_of(acc_rd_bank[0], acc_rd_addr);
    else           acc_rd_data <= {12{$urandom()}};
  end

  typedef struct {
    logic [1:0]       valid;
    logic [5:0]       base;
    logic [7:0]       scale;
    logic [7:0]       bias;
    logic [OUT_W-1:0] result;
    int               exp_bank;
    int               done_dly;
  } vec_t;

  vec_t vecs[6];
  int   n_tests;
  int   n_fail;

  function automatic vec_t mk(input logic [1:0] v, input logic [5:0] b, input logic [7:0] s,
                              input logic [7:0] bi, input logic [OUT_W-1:0] r,
                              input int eb, input int dd);
    vec_t t;
    t.valid = v; t.base = b; t.scale = s; t.bias = bi; t.result = r;
    t.exp_bank = eb; t.done_dly = dd;
    return t;
  endfunction

  task automatic chk(input string name, input logic [PSUM_W-1:0] act, input logic [PSUM_W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_ready(output bit got);
    got = 1'b0;
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        got = 1'b1;
        break;
      end
    end
    chk("ready_seen", got, 1'b1);
  endtask

  task automatic run_tile(input vec_t v, input bit leave_high);
    bit         got;
    logic       b;
    logic [5:0] a;
    logic [7:0] es;
    logic [7:0] eb;
    req_valid = v.valid;
    req_scale = {v.scale + 8'd1, v.scale};
    req_bias  = {~v.bias, v.bias};
    req_base  = {v.base, v.base};
    b  = v.exp_bank[0];
    es = b ? v.scale + 8'd1 : v.scale;
    eb = b ? ~v.bias : v.bias;
    wait_ready(got);
    if (!got) begin
      req_valid = '0;
      return;
    end
    chk("req_ready", req_ready, 2'b01 << v.exp_bank);
    @(negedge clk);
    chk("ppu_valid", ppu_valid, 1'b1);
    chk("ppu_scale", ppu_scale, es);
    chk("ppu_bias", ppu_bias, eb);
    chk("busy_stream", busy, 1'b1);
    for (int c = 0; c <= 16; c++) begin
      if (c > 0) @(negedge clk);
      chk("ready_quiet", req_ready, 2'b00);
      if (c < 16) begin
        a = v.base + 6'(c);
        chk("rd_en", acc_rd_en, 1'b1);
        chk("rd_addr", acc_rd_addr, a);
        chk("rd_bank", acc_rd_bank, b);
      end else begin
        chk("rd_en_end", acc_rd_en, 1'b0);
      end
      if (c == 0) chk("psum_pre", ppu_psum, '0);
      else begin
        a = v.base + 6'(c - 1);
        chk("psum_row", ppu_psum, psum_of(b, a));
        chk("ppu_valid_once", ppu_valid, 1'b0);
      end
    end
    @(negedge clk);
    chk("psum_post", ppu_psum, '0);
    for (int d = 0; d < v.done_dly; d++) begin
      chk("no_write_wait", out_wr_en, 1'b0);
      @(negedge clk);
    end
    if (ppu_done) begin
      ppu_done = 1'b0;
      @(negedge clk);
      chk("no_write_low", out_wr_en, 1'b0);
    end
    ppu_done = 1'b1;
    ppu_out  = v.result;
    @(negedge clk);
    chk("wr_en", out_wr_en, 1'b1);
    chk("wr_bank", out_wr_bank, b);
    chk("wr_data", out_wr_data, v.result);
    chk("scale_held", ppu_scale, es);
    if (!leave_high) ppu_done = 1'b0;
    req_valid = '0;
    ppu_out   = '0;
    @(negedge clk);
    chk("idle_busy", busy, 1'b0);
    chk("idle_wr", out_wr_en, 1'b0);
  endtask

  task automatic timeout_seq(input logic [1:0] valid, input int exp_bank, input bit clr_at_end);
    bit got;
    int bad;
    req_valid = valid;
    req_base  = '0;
    ppu_done  = 1'b0;
    wait_ready(got);
    if (!got) begin
      req_valid = '0;
      return;
    end
    chk("tmo_ready", req_ready, 2'b01 << exp_bank);
    req_valid = '0;
    bad = 0;
    for (int n = 1; n <= 272; n++) begin
      @(negedge clk);
      if (out_wr_en !== 1'b0 || timeout_err !== 1'b0 || busy !== 1'b1) bad++;
      if (clr_at_end && n == 272) err_clr = 1'b1;
    end
    chk("tmo_quiet", bad, 0);
    @(negedge clk);
    err_clr = 1'b0;
    chk("tmo_err", timeout_err, clr_at_end ? 1'b0 : 1'b1);
    chk("tmo_idle", busy, 1'b0);
    chk("tmo_no_wr", out_wr_en, 1'b0);
  endtask

  initial begin
    bit got;
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0; req_valid = '0; req_scale = '0; req_bias = '0; req_base = '0;
    ppu_done = 1'b0; ppu_out = '0; err_clr = 1'b0;

    vecs[0] = mk(2'b11,  6'd5, 8'h38, 8'h10, 128'hA0A0_0000_0000_0000_0000_0000_0000_0001, 0, 0);
    vecs[1] = mk(2'b11, 6'd10, 8'h40, 8'h21, 128'hB1B1_0000_0000_0000_0000_0000_0000_0002, 1, 0);
    vecs[2] = mk(2'b11, 6'd20, 8'h44, 8'h32, 128'hC2C2_0000_0000_0000_0000_0000_0000_0003, 0, 1);
    vecs[3] = mk(2'b01,  6'd5, 8'h48, 8'h43, 128'hD3D3_0000_0000_0000_0000_0000_0000_0004, 0, 0);
    vecs[4] = mk(2'b10, 6'd60, 8'h4C, 8'h54, 128'hE4E4_0000_0000_0000_0000_0000_0000_0005, 1, 2);
    vecs[5] = mk(2'b11, 6'd63, 8'h50, 8'h65, 128'hF5F5_0000_0000_0000_0000_0000_0000_0006, 0, 3);

    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", req_ready, 2'b00);
    chk("rst_valid", ppu_valid, 1'b0);
    chk("rst_rd_en", acc_rd_en, 1'b0);
    chk("rst_psum", ppu_psum, '0);
    chk("rst_wr", {out_wr_en, out_wr_data}, '0);
    chk("rst_err", timeout_err, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_tile(vecs[i], 1'b0);

    // Done level left high by one tile must not complete the next.
    run_tile(mk(2'b11, 6'd30, 8'h11, 8'h22, 128'h1234, 1, 0), 1'b1);
    run_tile(mk(2'b01, 6'd40, 8'h33, 8'h44, 128'h5678, 0, 20), 1'b0);

    timeout_seq(2'b10, 1, 1'b0);
    run_tile(mk(2'b01, 6'd1, 8'h55, 8'h66, 128'h9ABC, 0, 0), 1'b0);
    chk("err_sticky", timeout_err, 1'b1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_clr", timeout_err, 1'b0);
    timeout_seq(2'b01, 0, 1'b1);

    // Reset while streaming row 7 of a bank-1 tile.
    req_valid = 2'b11;
    req_base  = {6'd8, 6'd8};
    wait_ready(got);
    chk("rst_mid_grant", req_ready, 2'b10);
    repeat (8) @(negedge clk);
    chk("rst_mid_row7", acc_rd_addr, 6'd15);
    rst_n = 1'b0;
    req_valid = '0;
    #1;
    chk("amid_busy", busy, 1'b0);
    chk("amid_rd", {acc_rd_en, acc_rd_addr, acc_rd_bank}, '0);
    chk("amid_psum", ppu_psum, '0);
    chk("amid_ppu", {ppu_valid, ppu_scale, ppu_bias}, '0);
    chk("amid_wr", {out_wr_en, out_wr_bank, out_wr_data}, '0);
    chk("amid_ready", req_ready, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    run_tile(mk(2'b11, 6'd2, 8'h77, 8'h88, 128'hDEF0, 0, 0), 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
